instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit, a synchronous active-low reset sampled on the rising edge of clk.
REQ-003 The block SHALL have port in_valid, input, 1 bit, meaning a field bundle is offered.
REQ-004 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a bundle this cycle.
REQ-005 The block SHALL have input ports opcode (3 bits), op (2), Rn (3), Rd (3), Rm (3) and shift (2), carrying instruction fields.
REQ-006 The block SHALL have port imm, input, 16 bits, a signed immediate value.
REQ-007 The block SHALL have port base_load, input, 1 bit, requesting a load of the address counter.
REQ-008 The block SHALL have port base_addr, input, 8 bits, the value loaded into the address counter.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning an encoded word is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit, the sink acceptance signal.
REQ-011 The block SHALL have port out_instr, output, 16 bits, the encoded instruction word.
REQ-012 The block SHALL have port out_addr, output, 8 bits, the memory address of out_instr.
REQ-013 The block SHALL have port err, output, 1 bit, a one-cycle pulse marking a rejected bundle.
REQ-014 The block SHALL have port err_count, output, 8 bits, a saturating count of rejected bundles.
REQ-015 The block SHALL have parameter DEPTH, default 4, the output buffer depth in entries.

Function
REQ-016 The block SHALL place the common fields at out_instr[15:13]=opcode and out_instr[12:11]=op for every format.
REQ-017 The block SHALL use IMM8 format when opcode=110 and op=10: bits [10:8]=Rn and bits [7:0]=imm[7:0].
REQ-018 The block SHALL use IMM5 format when opcode is 011 or 100: bits [10:8]=Rn, [7:5]=Rd and [4:0]=imm[4:0].
REQ-019 The block SHALL use REG format for all other opcodes: bits [10:8]=Rn, [7:5]=Rd, [4:3]=shift and [2:0]=Rm.
REQ-020 The block SHALL, for opcode=110 with op=00, force bits [10:8] to 000.
REQ-021 The block SHALL reject an IMM8 bundle whose imm lies outside -128..127 and an IMM5 bundle whose imm lies outside -16..15; REG format never checks imm.
REQ-022 The block SHALL treat a bundle as accepted when in_valid and in_ready are both high in the same cycle.
REQ-023 The block SHALL drive in_ready high exactly when the buffer holds fewer than DEPTH entries, independent of out_ready in that cycle.
REQ-024 The block SHALL write each accepted, valid bundle into the FIFO buffer with one cycle of latency, so out_valid can rise at the earliest on the cycle after acceptance.
REQ-025 The block SHALL, for a rejected bundle, write nothing, pulse err high for the following cycle, and increment err_count, saturating at 255.
REQ-026 The block SHALL drive out_valid high exactly when the buffer is non-empty, with out_instr showing the head entry.
REQ-027 The block SHALL pop the head entry on an output handshake (out_valid and out_ready both high) and hold out_instr stable while out_valid is high and out_ready is low.
REQ-028 The block SHALL leave the occupancy count unchanged when a push and a pop occur in the same cycle.
REQ-029 The block SHALL present the address counter value on out_addr and increment it by one on each output handshake, wrapping from 255 to 0.
REQ-030 The block SHALL let base_load take priority over the handshake increment, so the counter becomes base_addr and the word handed off in that cycle uses the old address.

Reset
REQ-031 The block SHALL, while reset is low at a clock edge, empty the buffer and clear the address counter to 0, err to 0 and err_count to 0, which drives out_valid to 0 and in_ready to 1.
REQ-032 The block SHALL discard all buffered words when reset is asserted mid-operation, with no handshake completing in that cycle.

Structure
REQ-033 The block SHALL take its opcode constants (MOV=110, ALU=101, LDR=011, STR=100, HALT=111), the format enum (REG, IMM5, IMM8) and the immediate range limits from the shared package instr_pkg.
REQ-034 The block SHALL implement the buffer as one sub-module, instr_fifo, a synchronous FIFO of DEPTH entries by 16 bits with push, pop, full and empty signals.

Verification
REQ-035 The bench SHALL apply opcode=110, op=10, Rn=3, imm=-1 and require out_instr=0xD3FF at out_addr=0 one cycle later.
REQ-036 The bench SHALL apply opcode=011, Rn=2, Rd=5 with imm=16 and require err to pulse, err_count=1 and out_valid to stay low; with imm=-16 it SHALL require out_instr=0x62B0.
REQ-037 The bench SHALL apply opcode=101, op=10, Rn=1, Rd=2, shift=01, Rm=7 and require out_instr=0xB14F.
REQ-038 The bench SHALL hold out_ready=0 and offer 5 bundles, requiring in_ready to drop after 4 accepted; with out_ready then held at 1 it SHALL require the 4 words in order at addresses 0..3.
REQ-039 The bench SHALL pulse base_load with base_addr=255, stream 2 words, and require out_addr values 255 then 0.
REQ-040 The bench SHALL assert reset with 3 words buffered and require out_valid=0, in_ready=1 and out_addr=0 on the next cycle.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared constants for the instruction encoder: opcode values, word formats
// and the signed immediate range limits for the immediate-carrying formats.
package instr_pkg;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    typedef enum logic [1:0] {
        FMT_REG,
        FMT_IMM5,
        FMT_IMM8
    } fmt_t;

    localparam logic signed [15:0] IMM8_MIN = -16'sd128;
    localparam logic signed [15:0] IMM8_MAX = 16'sd127;
    localparam logic signed [15:0] IMM5_MIN = -16'sd16;
    localparam logic signed [15:0] IMM5_MAX = 16'sd15;

    function automatic fmt_t fmt_of(input logic [2:0] opcode, input logic [1:0] op);
        if (opcode == OPC_MOV && op == OP_MOV_IMM)
            return FMT_IMM8;
        if (opcode == OPC_LDR || opcode == OPC_STR)
            return FMT_IMM5;
        return FMT_REG;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of DEPTH 16-bit words; the head entry is always visible on dout.
module instr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into 16-bit words, rejects out-of-range immediates,
// and streams accepted words through a small FIFO tagged with a running address.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         opcode,
    input  logic [1:0]         op,
    input  logic [2:0]         Rn,
    input  logic [2:0]         Rd,
    input  logic [2:0]         Rm,
    input  logic [1:0]         shift,
    input  logic signed [15:0] imm,
    input  logic               base_load,
    input  logic [7:0]         base_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_instr,
    output logic [7:0]         out_addr,
    output logic               err,
    output logic [7:0]         err_count
);

    fmt_t        fmt;
    logic [15:0] word;
    logic        imm_bad;
    logic        accept;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [7:0]  addr;

    always_comb begin
        fmt     = fmt_of(opcode, op);
        word    = {opcode, op, Rn, Rd, shift, Rm};
        imm_bad = 1'b0;
        case (fmt)
            FMT_IMM8: begin
                word[10:0] = {Rn, imm[7:0]};
                imm_bad    = (imm < IMM8_MIN) || (imm > IMM8_MAX);
            end
            FMT_IMM5: begin
                word[10:0] = {Rn, Rd, imm[4:0]};
                imm_bad    = (imm < IMM5_MIN) || (imm > IMM5_MAX);
            end
            default: begin
                // Register-form MOV has no source base register.
                if (opcode == OPC_MOV && op == OP_MOV_REG)
                    word[10:8] = 3'b000;
            end
        endcase
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && !imm_bad;
    assign pop       = out_valid && out_ready;
    assign out_addr  = addr;

    instr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (word),
        .dout  (out_instr),
        .full  (full),
        .empty (empty)
    );

    // base_load wins over the handshake increment; the popped word keeps the old address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr      <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= accept && imm_bad;
            if (accept && imm_bad && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (base_load)
                addr <= base_addr;
            else if (pop)
                addr <= addr + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder, checked against a
// queue-based reference model of the encoder, buffer and address counter.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         opcode;
    logic [1:0]         op;
    logic [2:0]         Rn;
    logic [2:0]         Rd;
    logic [2:0]         Rm;
    logic [1:0]         shift;
    logic signed [15:0] imm;
    logic               base_load;
    logic [7:0]         base_addr;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_instr;
    logic [7:0]         out_addr;
    logic               err;
    logic [7:0]         err_count;

    int checks   = 0;
    int failures = 0;

    logic [15:0] q[$];
    logic [7:0]  addr_m;
    logic        err_m;
    int          cnt_m;

    instr_encoder #(
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .op        (op),
        .Rn        (Rn),
        .Rd        (Rd),
        .Rm        (Rm),
        .shift     (shift),
        .imm       (imm),
        .base_load (base_load),
        .base_addr (base_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoding built from field weights and integer range tests.
    function automatic logic [15:0] ref_word(input int opc, input int o, input int rn, input int rd,
                                             input int rm, input int sh, input int iv, output bit ok);
        int w;
        w  = opc * 8192 + o * 2048;
        ok = 1'b1;
        if (opc == 6 && o == 2) begin
            w += rn * 256 + (iv & 255);
            ok = (iv >= -128) && (iv <= 127);
        end else if (opc == 3 || opc == 4) begin
            w += rn * 256 + rd * 32 + (iv & 31);
            ok = (iv >= -16) && (iv <= 15);
        end else begin
            w += ((opc == 6 && o == 0) ? 0 : rn * 256) + rd * 32 + sh * 8 + rm;
        end
        return w[15:0];
    endfunction

    task automatic set_bundle(input int opc, input int o, input int rn, input int rd,
                              input int rm, input int sh, input int iv);
        in_valid = 1'b1;
        opcode   = 3'(opc);
        op       = 2'(o);
        Rn       = 3'(rn);
        Rd       = 3'(rd);
        Rm       = 3'(rm);
        shift    = 2'(sh);
        imm      = 16'(iv);
    endtask

    // Compare against the model at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        bit          ok;
        bit          acc;
        bit          popm;
        logic [15:0] w;
        @(negedge clk);
        check("out_valid", out_valid, 32'(q.size() > 0));
        check("in_ready", in_ready, 32'(q.size() < DEPTH));
        check("out_addr", out_addr, addr_m);
        check("err", err, err_m);
        check("err_count", err_count, cnt_m);
        if (q.size() > 0)
            check("out_instr", out_instr, q[0]);
        if (!reset) begin
            q.delete();
            addr_m = 8'd0;
            err_m  = 1'b0;
            cnt_m  = 0;
        end else begin
            w    = ref_word(int'(opcode), int'(op), int'(Rn), int'(Rd), int'(Rm), int'(shift),
                            int'(imm), ok);
            acc  = in_valid && (q.size() < DEPTH);
            popm = (q.size() > 0) && out_ready;
            if (popm)
                void'(q.pop_front());
            if (acc && ok)
                q.push_back(w);
            err_m = acc && !ok;
            if (err_m && cnt_m < 255)
                cnt_m++;
            if (base_load)
                addr_m = base_addr;
            else if (popm)
                addr_m = addr_m + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    logic [15:0] exp_words [4];
    bit          dummy_ok;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        base_load = 1'b0;
        base_addr = 8'd0;
        set_bundle(0, 0, 0, 0, 0, 0, 0);
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        addr_m = 8'd0;
        err_m  = 1'b0;
        cnt_m  = 0;
        reset  = 1'b1;

        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_addr", out_addr, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);

        // MOV immediate
        set_bundle(6, 2, 3, 0, 0, 0, -1);
        tick();
        in_valid = 1'b0;
        check("mov_imm8_instr", out_instr, 16'hD3FF);
        check("mov_imm8_addr", out_addr, 0);
        check("mov_imm8_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // LDR with imm just out of range, then at the negative limit
        set_bundle(3, 0, 2, 5, 0, 0, 16);
        tick();
        in_valid = 1'b0;
        check("ldr_bad_err", err, 1);
        check("ldr_bad_count", err_count, 1);
        check("ldr_bad_valid", out_valid, 0);
        tick();
        check("err_one_cycle", err, 0);
        set_bundle(3, 0, 2, 5, 0, 0, -16);
        tick();
        in_valid = 1'b0;
        check("ldr_imm5_instr", out_instr, 16'h62B0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ALU register form
        set_bundle(5, 2, 1, 2, 7, 1, 0);
        tick();
        in_valid = 1'b0;
        check("alu_reg_instr", out_instr, 16'hB14F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fill with the sink stalled, then drain in order
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_bundle(5, i % 4, i, 7 - i, i + 1, i % 4, 0);
            if (i < 4)
                exp_words[i] = ref_word(5, i % 4, i, 7 - i, i + 1, i % 4, 0, dummy_ok);
            check("fill_in_ready", in_ready, 32'(i < 4));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", out_valid, 1);
            check("drain_instr", out_instr, exp_words[i]);
            check("drain_addr", out_addr, i);
            tick();
        end
        check("drain_empty", out_valid, 0);
        out_ready = 1'b0;

        // Address wrap after a base load
        base_load = 1'b1;
        base_addr = 8'd255;
        tick();
        base_load = 1'b0;
        set_bundle(7, 1, 4, 4, 4, 2, 0);
        tick();
        set_bundle(0, 3, 1, 1, 1, 1, 0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("wrap_addr0", out_addr, 255);
        tick();
        check("wrap_addr1", out_addr, 0);
        tick();
        out_ready = 1'b0;

        // Reset with words buffered
        for (int i = 0; i < 3; i++) begin
            set_bundle(1, 1, i, i, i, 0, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b0;
        tick();
        reset     = 1'b1;
        out_ready = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_addr", out_addr, 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int iv;
            if ($urandom_range(0, 3) == 0)
                iv = int'($signed(16'($urandom())));
            else
                iv = int'($urandom_range(0, 400)) - 200;
            set_bundle(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), iv);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            base_load = ($urandom_range(0, 15) == 0);
            base_addr = 8'($urandom());
            reset     = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
